// File: rtl/tri_edge_walker.sv
// tri_edge_walker
//   Takes one triangle, computes its doubled signed area and the three edge
//   functions at the corner of its screen-clipped bounding box, then walks the
//   box in raster order. Edge values advance incrementally (one add per
//   step); the multiplies exist only in the one-cycle setup.
//
//   Optional build macro: TRI_EDGE_WALKER_SKIP_EN
//     When defined, pixels outside the triangle are stepped over internally at
//     one per cycle and only visible pixels are emitted. px_last then marks the
//     last visible pixel. When undefined, every bbox pixel is emitted.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tri_valid/tri_ready triangle handshake (ready only while idle)
//   x0..x2, y0..y2      vertex coordinates (unsigned)
//   px_valid/px_ready   pixel record handshake
//   px_x, px_y          pixel position
//   visible             pixel lies inside the triangle (all edges >= 0)
//   ua, va, wa          saturated edge weights for v0/v1/v2, 0 when not visible
//   a                   doubled triangle area, constant per triangle
//   px_last             final record of the triangle
module tri_edge_walker #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int EW    = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [9:0]  x2,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [8:0]  y2,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic        visible,
  output logic [17:0] ua,
  output logic [17:0] va,
  output logic [17:0] wa,
  output logic [18:0] a,
  output logic        px_last
);

  typedef enum logic [1:0] {IDLE, SETUP, WALK, DRAIN} state_t;
  typedef logic signed [EW-1:0] acc_t;

  localparam logic [9:0] X_CLIP = 10'(H_RES - 1);
  localparam logic [8:0] Y_CLIP = 9'(V_RES - 1);

  state_t state, state_nxt;

  // Latched vertices
  logic [9:0] vx [3];
  logic [8:0] vy [3];

  // Edge k runs from vertex i to vertex j: k=0 is E_12, k=1 is E_20, k=2 is E_01
  logic [9:0] ex_i [3], ex_j [3];
  logic [8:0] ey_i [3], ey_j [3];

  // Setup-cycle combinational results
  logic [9:0] bx_lo, bx_hi;
  logic [8:0] by_lo, by_hi;
  acc_t       s_e  [3];
  acc_t       s_dx [3];
  acc_t       s_dy [3];
  acc_t       s_a;

  // Walk state
  logic [9:0]  cur_x, x_lo, x_hi;
  logic [8:0]  cur_y, y_lo, y_hi;
  acc_t        e_cur [3];
  acc_t        e_row [3];
  acc_t        dx    [3];
  acc_t        dy    [3];
  logic [18:0] a_r;

  logic step, at_end, vis_raw, hs;

  function automatic acc_t ext_x(input logic [9:0] v);
    return acc_t'({{(EW-10){1'b0}}, v});
  endfunction

  function automatic acc_t ext_y(input logic [8:0] v);
    return acc_t'({{(EW-9){1'b0}}, v});
  endfunction

  // Non-negative values only reach here when visible; above 2^18-1 clamps
  function automatic logic [17:0] sat18(input acc_t e);
    if (e[EW-1])       return '0;
    if (|e[EW-2:18])   return '1;
    return e[17:0];
  endfunction

  always_comb begin
    ex_i[0] = vx[1]; ex_j[0] = vx[2]; ey_i[0] = vy[1]; ey_j[0] = vy[2];
    ex_i[1] = vx[2]; ex_j[1] = vx[0]; ey_i[1] = vy[2]; ey_j[1] = vy[0];
    ex_i[2] = vx[0]; ex_j[2] = vx[1]; ey_i[2] = vy[0]; ey_j[2] = vy[1];
  end

  // Bounding box, each bound clipped to the screen
  always_comb begin
    bx_lo = vx[0];
    bx_hi = vx[0];
    by_lo = vy[0];
    by_hi = vy[0];
    for (int k = 1; k < 3; k++) begin
      if (vx[k] < bx_lo) bx_lo = vx[k];
      if (vx[k] > bx_hi) bx_hi = vx[k];
      if (vy[k] < by_lo) by_lo = vy[k];
      if (vy[k] > by_hi) by_hi = vy[k];
    end
    if (bx_lo > X_CLIP) bx_lo = X_CLIP;
    if (bx_hi > X_CLIP) bx_hi = X_CLIP;
    if (by_lo > Y_CLIP) by_lo = Y_CLIP;
    if (by_hi > Y_CLIP) by_hi = Y_CLIP;
  end

  // E(p) = dY*(py-yi) + dX*(px-xi), with dX = -(yj-yi), dY = xj-xi
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      s_dy[k] = ext_x(ex_j[k]) - ext_x(ex_i[k]);
      s_dx[k] = ext_y(ey_i[k]) - ext_y(ey_j[k]);
      s_e[k]  = s_dy[k] * (ext_y(by_lo) - ext_y(ey_i[k]))
              + s_dx[k] * (ext_x(bx_lo) - ext_x(ex_i[k]));
    end
    // a = E_01 evaluated at v2
    s_a = s_dy[2] * (ext_y(vy[2]) - ext_y(vy[0]))
        + s_dx[2] * (ext_x(vx[2]) - ext_x(vx[0]));
  end

  assign vis_raw   = !e_cur[0][EW-1] && !e_cur[1][EW-1] && !e_cur[2][EW-1];
  assign at_end    = (cur_x == x_hi) && (cur_y == y_hi);
  assign tri_ready = (state == IDLE);
  assign a         = a_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      x_lo  <= '0;
      x_hi  <= '0;
      y_lo  <= '0;
      y_hi  <= '0;
      a_r   <= '0;
      for (int k = 0; k < 3; k++) begin
        vx[k]    <= '0;
        vy[k]    <= '0;
        e_cur[k] <= '0;
        e_row[k] <= '0;
        dx[k]    <= '0;
        dy[k]    <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && tri_valid) begin
        vx[0] <= x0; vx[1] <= x1; vx[2] <= x2;
        vy[0] <= y0; vy[1] <= y1; vy[2] <= y2;
      end
      if (state == SETUP) begin
        cur_x <= bx_lo;
        cur_y <= by_lo;
        x_lo  <= bx_lo;
        x_hi  <= bx_hi;
        y_lo  <= by_lo;
        y_hi  <= by_hi;
        a_r   <= s_a[18:0];
        for (int k = 0; k < 3; k++) begin
          e_cur[k] <= s_e[k];
          e_row[k] <= s_e[k];
          dx[k]    <= s_dx[k];
          dy[k]    <= s_dy[k];
        end
      end else if (step) begin
        if (cur_x < x_hi) begin
          cur_x <= cur_x + 10'd1;
          for (int k = 0; k < 3; k++) e_cur[k] <= e_cur[k] + dx[k];
        end else if (cur_y < y_hi) begin
          cur_x <= x_lo;
          cur_y <= cur_y + 9'd1;
          for (int k = 0; k < 3; k++) begin
            e_row[k] <= e_row[k] + dy[k];
            e_cur[k] <= e_row[k] + dy[k];
          end
        end
      end
    end
  end

`ifdef TRI_EDGE_WALKER_SKIP_EN
  // Whether a visible pixel is the last one is only known once the scan has
  // found the next visible pixel or run off the end of the box, so each
  // visible pixel is parked in a one-entry buffer until then.
  logic        ob_full, load;
  logic [9:0]  ob_x;
  logic [8:0]  ob_y;
  logic [17:0] ob_u, ob_v, ob_w;

  always_comb begin
    px_valid = ob_full && (((state == WALK) && vis_raw) || (state == DRAIN));
    hs       = px_valid && px_ready;
    load     = (state == WALK) && vis_raw && (!ob_full || hs);
    step     = (state == WALK) && (!vis_raw || !ob_full || hs);
    visible  = ob_full;
    px_x     = ob_x;
    px_y     = ob_y;
    ua       = ob_full ? ob_u : '0;
    va       = ob_full ? ob_v : '0;
    wa       = ob_full ? ob_w : '0;
    px_last  = px_valid && (state == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_full <= 1'b0;
      ob_x    <= '0;
      ob_y    <= '0;
      ob_u    <= '0;
      ob_v    <= '0;
      ob_w    <= '0;
    end else if (load) begin
      ob_full <= 1'b1;
      ob_x    <= cur_x;
      ob_y    <= cur_y;
      ob_u    <= sat18(e_cur[0]);
      ob_v    <= sat18(e_cur[1]);
      ob_w    <= sat18(e_cur[2]);
    end else if (hs) begin
      ob_full <= 1'b0;
    end
  end
`else
  always_comb begin
    px_valid = (state == WALK);
    hs       = px_valid && px_ready;
    step     = hs;
    visible  = px_valid && vis_raw;
    px_x     = cur_x;
    px_y     = cur_y;
    ua       = visible ? sat18(e_cur[0]) : '0;
    va       = visible ? sat18(e_cur[1]) : '0;
    wa       = visible ? sat18(e_cur[2]) : '0;
    px_last  = px_valid && at_end;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (tri_valid) state_nxt = SETUP;
      // a <= 0 covers clockwise and degenerate triangles
      SETUP: state_nxt = (s_a > acc_t'(0)) ? WALK : IDLE;
      WALK: begin
        if (step && at_end) begin
`ifdef TRI_EDGE_WALKER_SKIP_EN
          state_nxt = (vis_raw || ob_full) ? DRAIN : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      DRAIN: if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tri_edge_walker.sv
// Bench for tri_edge_walker: table of triangles with hand-derived area and
// record counts, hand sequences for latency, saturation, clipping, stalls and
// mid-walk reset, plus random triangles with random back-pressure. All pixel
// records are compared against a model that evaluates the edge functions
// directly at every pixel of the clipped bounding box.
module tb_tri_edge_walker;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst_n, tri_valid, tri_ready, px_valid, px_ready, px_last, visible;
  logic [9:0]  x0, x1, x2, px_x;
  logic [8:0]  y0, y1, y2, px_y;
  logic [17:0] ua, va, wa;
  logic [18:0] a;

  always #5 clk = ~clk;

  tri_edge_walker dut (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .visible(visible), .ua(ua), .va(va), .wa(wa), .a(a), .px_last(px_last)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        vis;
    logic [17:0] u, v, w;
    logic        last;
    logic [18:0] a;
  } rec_t;

  typedef struct {
    int vx0, vy0, vx1, vy1, vx2, vy2;
    int exp_a, n_all, n_vis;
  } vec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   total = 0, bad = 0;
  int   max_px_x;

  task automatic chk(input bit ok, input string name, input string info);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  function automatic string rs(input rec_t r);
    return $sformatf("(x=%0d y=%0d vis=%0b u=%0d v=%0d w=%0d last=%0b a=%0d)",
                     r.x, r.y, r.vis, r.u, r.v, r.w, r.last, r.a);
  endfunction

  function automatic rec_t dut_rec();
    rec_t r;
    r = '{px_x, px_y, visible, ua, va, wa, px_last, a};
    return r;
  endfunction

  function automatic int edge_fn(int xi, int yi, int xj, int yj, int px, int py);
    return (xj - xi) * (py - yi) - (yj - yi) * (px - xi);
  endfunction

  function automatic int sat(int e);
    return (e > 262143) ? 262143 : e;
  endfunction

  function automatic int clip(int v, int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  // Expected record list for one triangle
  task automatic build_model(input int ax0, ay0, ax1, ay1, ax2, ay2);
    int area, xl, xh, yl, yh, e12, e20, e01;
    bit vis;
    rec_t r;
    exp_q.delete();
    area = edge_fn(ax0, ay0, ax1, ay1, ax2, ay2);
    if (area <= 0) return;
    xl = clip((ax0 < ax1) ? ((ax0 < ax2) ? ax0 : ax2) : ((ax1 < ax2) ? ax1 : ax2), H);
    xh = clip((ax0 > ax1) ? ((ax0 > ax2) ? ax0 : ax2) : ((ax1 > ax2) ? ax1 : ax2), H);
    yl = clip((ay0 < ay1) ? ((ay0 < ay2) ? ay0 : ay2) : ((ay1 < ay2) ? ay1 : ay2), V);
    yh = clip((ay0 > ay1) ? ((ay0 > ay2) ? ay0 : ay2) : ((ay1 > ay2) ? ay1 : ay2), V);
    for (int py = yl; py <= yh; py++) begin
      for (int px = xl; px <= xh; px++) begin
        e12 = edge_fn(ax1, ay1, ax2, ay2, px, py);
        e20 = edge_fn(ax2, ay2, ax0, ay0, px, py);
        e01 = edge_fn(ax0, ay0, ax1, ay1, px, py);
        vis = (e12 >= 0) && (e20 >= 0) && (e01 >= 0);
`ifdef TRI_EDGE_WALKER_SKIP_EN
        if (!vis) continue;
`endif
        r.x    = 10'(px);
        r.y    = 9'(py);
        r.vis  = vis;
        r.u    = vis ? 18'(sat(e12)) : 18'd0;
        r.v    = vis ? 18'(sat(e20)) : 18'd0;
        r.w    = vis ? 18'(sat(e01)) : 18'd0;
        r.last = 1'b0;
        r.a    = 19'(area);
        exp_q.push_back(r);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
  endtask

  // Drive a triangle for one cycle; returns at the negedge of the setup cycle
  task automatic send_tri(input int ax0, ay0, ax1, ay1, ax2, ay2);
    @(negedge clk);
    x0 = 10'(ax0); y0 = 9'(ay0);
    x1 = 10'(ax1); y1 = 9'(ay1);
    x2 = 10'(ax2); y2 = 9'(ay2);
    tri_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    chk(!px_valid && !tri_ready, "setup_cycle",
        $sformatf("px_valid=%0b tri_ready=%0b, required 0 0", px_valid, tri_ready));
  endtask

  // Consume records, comparing every presented (also stalled) record against
  // the head of exp_q. abort_at>0 pulls reset while that record is presented.
  task automatic run_walk(input int ready_pct, input int max_cyc, input int abort_at,
                          output int n_rec, output int first_cyc, output int idle_cyc);
    int  cyc = 0;
    bit  done = 0, rdy;
    rec_t r;
    n_rec = 0; first_cyc = -1; idle_cyc = -1; max_px_x = 0;
    got_q.delete();
    while (!done) begin
      @(negedge clk);
      if (px_valid) begin
        r = dut_rec();
        if (first_cyc < 0) first_cyc = cyc;
        if (int'(px_x) > max_px_x) max_px_x = int'(px_x);
        if (exp_q.size() == 0)
          chk(1'b0, "extra_record", $sformatf("got %s, required no record", rs(r)));
        else
          chk(r == exp_q[0], "record", $sformatf("got %s required %s", rs(r), rs(exp_q[0])));
        if (abort_at > 0 && n_rec == abort_at - 1) begin
          rst_n = 1'b0;
          #1;
          chk(!px_valid && tri_ready, "async_reset",
              $sformatf("px_valid=%0b tri_ready=%0b, required 0 1", px_valid, tri_ready));
          done = 1;
        end
      end else if (tri_ready) begin
        idle_cyc = cyc;
        if (exp_q.size() != 0)
          chk(1'b0, "missing_records", $sformatf("%0d left, required 0", exp_q.size()));
        done = 1;
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (!done && px_valid && rdy) begin
        n_rec++;
        got_q.push_back(dut_rec());
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      px_ready = rdy;
      cyc++;
      if (!done && cyc > max_cyc) begin
        chk(1'b0, "timeout", $sformatf("walk not finished after %0d cycles", max_cyc));
        done = 1;
      end
    end
    px_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[5];
    int   n, first, idle, exp_n, found;
    rec_t want;

    rst_n = 1'b0; tri_valid = 1'b0; px_ready = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; y0 = '0; y1 = '0; y2 = '0;
    #12;
    chk(tri_ready && !px_valid && !px_last && !visible && ua == 0 && va == 0 && wa == 0
        && a == 0 && px_x == 0 && px_y == 0, "reset_state",
        $sformatf("ready=%0b valid=%0b last=%0b %s, required ready=1 all else 0",
                  tri_ready, px_valid, px_last, rs(dut_rec())));
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{0, 0, 8, 0, 0, 8, 64, 81, 45};
    tbl[1] = '{0, 0, 0, 8, 8, 0, -64, 0, 0};
    tbl[2] = '{5, 5, 5, 5, 5, 5, 0, 0, 0};
    tbl[3] = '{600, 0, 700, 0, 600, 10, 1000, 440, 344};
    tbl[4] = '{10, 20, 2, 3, 30, 5, 460, 522, -1};

    for (int i = 0; i < 5; i++) begin
      build_model(tbl[i].vx0, tbl[i].vy0, tbl[i].vx1, tbl[i].vy1, tbl[i].vx2, tbl[i].vy2);
      send_tri(tbl[i].vx0, tbl[i].vy0, tbl[i].vx1, tbl[i].vy1, tbl[i].vx2, tbl[i].vy2);
      run_walk(100, 5000, 0, n, first, idle);
`ifdef TRI_EDGE_WALKER_SKIP_EN
      exp_n = tbl[i].n_vis;
`else
      exp_n = tbl[i].n_all;
      if (tbl[i].n_all > 0)
        chk(first == 0, "first_latency", $sformatf("vec %0d first px_valid at +%0d, required +0", i, first));
`endif
      if (exp_n >= 0)
        chk(n == exp_n, "record_count", $sformatf("vec %0d got %0d required %0d", i, n, exp_n));
      chk(a == 19'(tbl[i].exp_a), "area",
          $sformatf("vec %0d got %0d required %0d", i, a, 19'(tbl[i].exp_a)));
      if (tbl[i].n_all == 0)
        chk(idle == 0, "reject_idle", $sformatf("vec %0d tri_ready back at +%0d, required +0", i, idle));
      if (i == 3)
        chk(max_px_x <= H - 1, "x_clip", $sformatf("max px_x %0d required <= %0d", max_px_x, H - 1));
      if (i == 0) begin
        found = 0;
        foreach (got_q[k]) begin
          if (got_q[k].x == 0 && got_q[k].y == 0) begin
            found++;
            chk(got_q[k].vis && got_q[k].u == 64 && got_q[k].v == 0 && got_q[k].w == 0,
                "pix_0_0", $sformatf("got %s required vis=1 u=64 v=0 w=0", rs(got_q[k])));
          end
          if (got_q[k].x == 4 && got_q[k].y == 4) begin
            found++;
            chk(got_q[k].vis && got_q[k].u == 0 && got_q[k].v == 32 && got_q[k].w == 32,
                "pix_4_4", $sformatf("got %s required vis=1 u=0 v=32 w=32", rs(got_q[k])));
          end
        end
        chk(found == 2, "pix_found", $sformatf("found %0d of (0,0),(4,4), required 2", found));
        if (got_q.size() > 0) begin
          want = got_q[got_q.size() - 1];
`ifdef TRI_EDGE_WALKER_SKIP_EN
          chk(want.last && want.x == 0 && want.y == 8, "last_pos",
              $sformatf("got %s required last at (0,8)", rs(want)));
`else
          chk(want.last && want.x == 8 && want.y == 8, "last_pos",
              $sformatf("got %s required last at (8,8)", rs(want)));
`endif
        end
      end
    end

    // Large triangle: first record saturates ua; abort with reset afterwards
    exp_q.delete();
    send_tri(0, 0, 639, 0, 0, 479);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (px_valid) found = 1;
    end
    want = '{10'd0, 9'd0, 1'b1, 18'd262143, 18'd0, 18'd0, 1'b0, 19'd306081};
    chk(found == 1 && dut_rec() == want, "big_first",
        $sformatf("valid=%0d got %s required %s", found, rs(dut_rec()), rs(want)));
    pulse_reset();

    // Same 8x8 triangle under random back-pressure
    build_model(0, 0, 8, 0, 0, 8);
    exp_n = exp_q.size();
    send_tri(0, 0, 8, 0, 0, 8);
    run_walk(45, 5000, 0, n, first, idle);
    chk(n == exp_n, "stall_count", $sformatf("got %0d required %0d", n, exp_n));

    // Reset while the 20th record is presented, then a clean triangle
    build_model(0, 0, 8, 0, 0, 8);
    send_tri(0, 0, 8, 0, 0, 8);
    run_walk(100, 5000, 20, n, first, idle);
    @(negedge clk);
    rst_n = 1'b1;
    build_model(0, 0, 8, 0, 0, 8);
    exp_n = exp_q.size();
    send_tri(0, 0, 8, 0, 0, 8);
    run_walk(100, 5000, 0, n, first, idle);
    chk(n == exp_n, "after_reset_count", $sformatf("got %0d required %0d", n, exp_n));

    // tri_valid held during a walk must be ignored
    build_model(0, 0, 4, 0, 0, 4);
    exp_n = exp_q.size();
    send_tri(0, 0, 4, 0, 0, 4);
    x0 = 10'd100; y0 = 9'd100; x1 = 10'd110; y1 = 9'd100; x2 = 10'd100; y2 = 9'd110;
    tri_valid = 1'b1;
    run_walk(70, 5000, 0, n, first, idle);
    tri_valid = 1'b0;
    chk(n == exp_n, "busy_ignore", $sformatf("got %0d required %0d", n, exp_n));

    // Random triangles, some straddling or beyond the right/bottom edge
    for (int t = 0; t < 12; t++) begin
      int bx, by, vx[3], vy[3];
      bx = (t % 3 == 2) ? int'($urandom_range(600, 1000)) : int'($urandom_range(0, 620));
      by = (t % 3 == 2) ? int'($urandom_range(440, 490)) : int'($urandom_range(0, 460));
      for (int k = 0; k < 3; k++) begin
        vx[k] = bx + int'($urandom_range(0, 22));
        vy[k] = by + int'($urandom_range(0, 20));
        if (vx[k] > 1023) vx[k] = 1023;
        if (vy[k] > 511) vy[k] = 511;
      end
      build_model(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
      exp_n = exp_q.size();
      send_tri(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
      run_walk(60, 5000, 0, n, first, idle);
      chk(n == exp_n, "rand_count", $sformatf("tri %0d got %0d required %0d", t, n, exp_n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
